fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the IF stage: owns the PC register and drives it into instruction_memory.
//  Generates IF/ID write-enable and flush so id_ir holds, bubbles or loads.
//  Handles stall, taken-branch redirect, HALT opcode and a post-reset boot wait.
//  Sits between the hazard/branch logic (EX) and the pc / id_ir pipeline registers.
// PARAMETERS
//  ADDR_W       8        PC width; instruction_memory address width
//  RESET_PC     8'h00    PC value loaded on reset
//  PC_STEP      1        PC increment per fetch (instruction words)
//  HALT_OPCODE  5'h1F    opcode in ID that halts fetch
//  BOOT_CYCLES  2        cycles after reset release before the first fetch (>=1)
//  CNT_W        16       width of perf counters (FETCH_PERF_EN only)
// PORTS
//  clock          in   1       single clock; all state updates on its rising edge
//  reset          in   1       asynchronous, active-low; 0 = reset asserted
//  stall          in   1       hazard unit: freeze IF and IF/ID this cycle
//  branch_taken   in   1       EX: redirect fetch this cycle
//  branch_target  in   ADDR_W  redirect address, valid with branch_taken
//  id_opcode      in   5       opcode currently in id_ir
//  id_valid       in   1       id_ir holds a real (non-bubble) instruction
//  resume         in   1       leave HALT (single-cycle pulse)
//  pc             out  ADDR_W  fetch address (registered)
//  if_id_write    out  1       load id_ir this edge (combinational)
//  if_id_flush    out  1       load bubble into id_ir this edge (combinational)
//  fetch_valid    out  1       instruction on memory output is live (combinational)
//  halted         out  1       1 while in HALT (combinational from state)
//  stall_count    out  CNT_W   FETCH_PERF_EN only
//  flush_count    out  CNT_W   FETCH_PERF_EN only
// BEHAVIOUR
//  - FSM states: BOOT, RUN, HALT. Reset (reset=0) enters BOOT asynchronously, with
//    pc=RESET_PC and boot counter=0; counters=0. Reset mid-operation discards everything.
//  - BOOT: pc held, if_id_write=0, if_id_flush=1, fetch_valid=0. Counter increments each
//    cycle; on the edge where counter==BOOT_CYCLES-1, go to RUN.
//  - RUN, priority per cycle:
//      1 branch_taken: pc<=branch_target, if_id_write=1, if_id_flush=1. Overrides stall
//        and halt, because the halting instruction is younger and is squashed.
//      2 id_valid && id_opcode==HALT_OPCODE: go to HALT, pc held, if_id_write=0,
//        if_id_flush=0. Overrides stall.
//      3 stall: pc held, if_id_write=0, if_id_flush=0.
//      4 otherwise: pc<=pc+PC_STEP modulo 2^ADDR_W (8'hFF+1 -> 8'h00), if_id_write=1,
//        if_id_flush=0.
//    In RUN, fetch_valid=1.
//  - HALT: pc held, if_id_write=0, if_id_flush=0, fetch_valid=0, halted=1.
//    - branch_taken and stall are ignored.
//    - resume=1: go to RUN on the next edge. pc is unchanged and fetch continues at the
//      instruction after HALT.
//    - The halt instruction still sits in id_ir. On the first RUN cycle, if_id_write=1
//      replaces it. A re-halt on that cycle is suppressed by a one-cycle guard flag.
//  - Latency: redirect is seen on pc 1 cycle after branch_taken. The wrong-path fetch is
//    squashed in the same cycle through if_id_flush.
//  - Outside BOOT, if_id_flush=1 only when branch_taken is honoured.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    - stall_count +1 on each RUN cycle where rule 3 wins.
//    - flush_count +1 on each RUN cycle where rule 1 wins.
//    - Both saturate at all-ones and clear only on reset.
//  FETCH_PERF_EN undefined: count ports and logic are absent; all else is identical.
// TESTING
//  - reset=0 then release, BOOT_CYCLES=2 -> pc=00, fetch_valid=0 for 2 cycles, then RUN;
//    pc 00,01,02...
//  - free run from pc=FE -> FE,FF,00,01; if_id_write=1, if_id_flush=0 throughout.
//  - stall=1 for 3 cycles at pc=05 -> pc stays 05, if_id_write=0; pc=06 on the cycle
//    after stall drops.
//  - stall=1 with branch_taken=1, target=40 -> if_id_flush=1 that cycle, pc=40 next
//    cycle.
//  - id_opcode=1F, id_valid=1 at pc=10 -> halted=1, pc=10 held 5 cycles. resume pulse
//    -> RUN, pc 10,11; no re-halt.
//  - FETCH_PERF_EN: 4 stalls + 2 branches -> stall_count=4, flush_count=2.
//    reset=0 mid-run -> both counts 0, pc=00, state BOOT.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer.
//   Owns the PC register that addresses instruction_memory. It also generates the IF/ID
//   write-enable and flush, so id_ir holds, loads a bubble, or loads the fetched word.
//   It handles stall, taken-branch redirect, the HALT opcode and a wait after reset.
//
// Optional feature macro: FETCH_PERF_EN (adds saturating stall/flush counters).
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   asynchronous, active-low
//   stall          in   freeze IF and IF/ID this cycle
//   branch_taken   in   redirect fetch to branch_target this cycle
//   branch_target  in   redirect address
//   id_opcode      in   opcode currently in id_ir
//   id_valid       in   id_ir holds a real instruction
//   resume         in   leave HALT (pulse)
//   pc             out  registered fetch address
//   if_id_write    out  load id_ir this edge
//   if_id_flush    out  load bubble into id_ir this edge
//   fetch_valid    out  memory output is a live instruction
//   halted         out  1 while in HALT
//   stall_count    out  cycles lost to stall (FETCH_PERF_EN only)
//   flush_count    out  honoured redirects (FETCH_PERF_EN only)
module fetch_ctrl #(
  parameter int unsigned          ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter int unsigned          PC_STEP     = 1,
  parameter logic [4:0]           HALT_OPCODE = 5'h1F,
  parameter int unsigned          BOOT_CYCLES = 2
`ifdef FETCH_PERF_EN
  ,
  parameter int unsigned          CNT_W       = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [4:0]        id_opcode,
  input  logic              id_valid,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              fetch_valid,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int unsigned       BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [BOOT_W-1:0] boot_q, boot_d;
  // Set for the first RUN cycle after resume: the halt instruction is still in id_ir.
  logic              guard_q, guard_d;
  logic              take_branch;
  logic              take_stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    boot_d      = boot_q;
    guard_d     = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    fetch_valid = 1'b0;
    take_branch = 1'b0;
    take_stall  = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        if_id_flush = 1'b1;
        if (boot_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_d = boot_q + 1'b1;
        end
      end
      ST_RUN: begin
        fetch_valid = 1'b1;
        if (branch_taken) begin
          // The halting instruction is younger than the branch, so it is squashed.
          pc_d        = branch_target;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          take_branch = 1'b1;
        end else if (id_valid && (id_opcode == HALT_OPCODE) && !guard_q) begin
          state_d = ST_HALT;
        end else if (stall) begin
          take_stall = 1'b1;
        end else begin
          pc_d        = pc_q + ADDR_W'(PC_STEP);
          if_id_write = 1'b1;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d = ST_RUN;
          guard_d = 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      boot_q  <= '0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      boot_q  <= boot_d;
      guard_q <= guard_d;
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (take_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (take_branch && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = take_stall ^ take_branch;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl (default parameters).
module tb_fetch_ctrl;

  logic       clock;
  logic       reset;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [4:0] id_opcode;
  logic       id_valid;
  logic       resume;
  logic [7:0] pc;
  logic       if_id_write;
  logic       if_id_flush;
  logic       fetch_valid;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  int total = 0;
  int bad   = 0;

  fetch_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_opcode     (id_opcode),
    .id_valid      (id_valid),
    .resume        (resume),
    .pc            (pc),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .fetch_valid   (fetch_valid),
    .halted        (halted)
`ifdef FETCH_PERF_EN
    ,
    .stall_count   (stall_count),
    .flush_count   (flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    id_opcode     = 5'h00;
    id_valid      = 1'b0;
    resume        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  // Redirect to a target from RUN and land on it.
  task automatic jump(input logic [7:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
    tick();
    branch_taken  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    // Two BOOT cycles.
    for (int i = 0; i < 2; i++) begin
      total++;
      if (pc !== 8'h00 || fetch_valid !== 1'b0 || if_id_write !== 1'b0 ||
          if_id_flush !== 1'b1 || halted !== 1'b0) begin
        $display("FAIL boot_cycle%0d got pc=%h fv=%b wr=%b fl=%b h=%b want pc=00 fv=0 wr=0 fl=1 h=0",
                 i, pc, fetch_valid, if_id_write, if_id_flush, halted);
        bad++;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pc !== 8'(i) || fetch_valid !== 1'b1 || if_id_write !== 1'b1 ||
          if_id_flush !== 1'b0) begin
        $display("FAIL run_start%0d got pc=%h fv=%b wr=%b fl=%b want pc=%h fv=1 wr=1 fl=0",
                 i, pc, fetch_valid, if_id_write, if_id_flush, 8'(i));
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
    jump(8'hFE);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (pc !== exp_pc[i] || if_id_write !== 1'b1 || if_id_flush !== 1'b0) begin
        $display("FAIL wrap%0d got pc=%h wr=%b fl=%b want pc=%h wr=1 fl=0",
                 i, pc, if_id_write, if_id_flush, exp_pc[i]);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    jump(8'h05);
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pc !== 8'h05 || if_id_write !== 1'b0 || if_id_flush !== 1'b0 ||
          fetch_valid !== 1'b1) begin
        $display("FAIL stall%0d got pc=%h wr=%b fl=%b fv=%b want pc=05 wr=0 fl=0 fv=1",
                 i, pc, if_id_write, if_id_flush, fetch_valid);
        bad++;
      end
      tick();
    end
    stall = 1'b0;
    #1;
    total++;
    if (pc !== 8'h05 || if_id_write !== 1'b1) begin
      $display("FAIL stall_release got pc=%h wr=%b want pc=05 wr=1", pc, if_id_write);
      bad++;
    end
    tick();
    total++;
    if (pc !== 8'h06) begin
      $display("FAIL stall_after got pc=%h want 06", pc);
      bad++;
    end
  endtask

  task automatic test_branch_over_stall();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h40;
    #1;
    total++;
    if (if_id_flush !== 1'b1 || if_id_write !== 1'b1) begin
      $display("FAIL br_stall_flush got fl=%b wr=%b want fl=1 wr=1", if_id_flush, if_id_write);
      bad++;
    end
    tick();
    stall        = 1'b0;
    branch_taken = 1'b0;
    #1;
    total++;
    if (pc !== 8'h40 || if_id_flush !== 1'b0) begin
      $display("FAIL br_stall_pc got pc=%h fl=%b want pc=40 fl=0", pc, if_id_flush);
      bad++;
    end
    // Branch beats a halt sitting in ID.
    id_valid      = 1'b1;
    id_opcode     = 5'h1F;
    branch_taken  = 1'b1;
    branch_target = 8'h22;
    #1;
    total++;
    if (if_id_flush !== 1'b1) begin
      $display("FAIL br_halt_flush got fl=%b want 1", if_id_flush);
      bad++;
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (pc !== 8'h22 || halted !== 1'b0) begin
      $display("FAIL br_halt_pc got pc=%h h=%b want pc=22 h=0", pc, halted);
      bad++;
    end
  endtask

  task automatic test_halt();
    jump(8'h10);
    id_valid  = 1'b1;
    id_opcode = 5'h1F;
    stall     = 1'b1;
    #1;
    total++;
    if (if_id_write !== 1'b0 || if_id_flush !== 1'b0 || halted !== 1'b0) begin
      $display("FAIL halt_enter got wr=%b fl=%b h=%b want wr=0 fl=0 h=0",
               if_id_write, if_id_flush, halted);
      bad++;
    end
    tick();
    // Branch and stall must be ignored while halted.
    branch_taken  = 1'b1;
    branch_target = 8'h77;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (halted !== 1'b1 || pc !== 8'h10 || fetch_valid !== 1'b0 ||
          if_id_write !== 1'b0 || if_id_flush !== 1'b0) begin
        $display("FAIL halt_hold%0d got h=%b pc=%h fv=%b wr=%b fl=%b want h=1 pc=10 fv=0 wr=0 fl=0",
                 i, halted, pc, fetch_valid, if_id_write, if_id_flush);
        bad++;
      end
      tick();
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
    resume       = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    // Halt instruction still in ID: guard must suppress re-halt.
    total++;
    if (halted !== 1'b0 || pc !== 8'h10 || if_id_write !== 1'b1 || fetch_valid !== 1'b1) begin
      $display("FAIL resume_first got h=%b pc=%h wr=%b fv=%b want h=0 pc=10 wr=1 fv=1",
               halted, pc, if_id_write, fetch_valid);
      bad++;
    end
    tick();
    id_valid = 1'b0;
    #1;
    total++;
    if (pc !== 8'h11 || halted !== 1'b0) begin
      $display("FAIL resume_next got pc=%h h=%b want pc=11 h=0", pc, halted);
      bad++;
    end
    tick();
    total++;
    if (pc !== 8'h12) begin
      $display("FAIL resume_run got pc=%h want 12", pc);
      bad++;
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b0;
    jump(8'h30);
    jump(8'h50);
    total++;
    if (stall_count !== 16'd4 || flush_count !== 16'd2) begin
      $display("FAIL perf_counts got s=%0d f=%0d want s=4 f=2", stall_count, flush_count);
      bad++;
    end
  endtask
`endif

  task automatic test_mid_reset();
    jump(8'h66);
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (pc !== 8'h00 || fetch_valid !== 1'b0 || if_id_flush !== 1'b1 || halted !== 1'b0) begin
      $display("FAIL mid_reset got pc=%h fv=%b fl=%b h=%b want pc=00 fv=0 fl=1 h=0",
               pc, fetch_valid, if_id_flush, halted);
      bad++;
    end
`ifdef FETCH_PERF_EN
    total++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      $display("FAIL mid_reset_counts got s=%0d f=%0d want 0 0", stall_count, flush_count);
      bad++;
    end
`endif
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (fetch_valid !== 1'b0 || pc !== 8'h00) begin
      $display("FAIL reboot_wait got fv=%b pc=%h want fv=0 pc=00", fetch_valid, pc);
      bad++;
    end
    tick();
    total++;
    if (fetch_valid !== 1'b1 || pc !== 8'h00) begin
      $display("FAIL reboot_run got fv=%b pc=%h want fv=1 pc=00", fetch_valid, pc);
      bad++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_wrap();
    test_stall();
    test_branch_over_stall();
    test_halt();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
